// File: rtl/params_pkg.sv
// Shared AXI width parameters, burst-type encoding and response codes used by
// the read responder and its burst address generator.
package params_pkg;

  localparam int AXI_ID_WIDTH   = 6;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator for AXI FIXED/INCR/WRAP bursts.
// Size must already be clamped to the bus width by the caller.
module axi_burst_addr
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Wrap window is (len+1) beats; keep the window base, let the offset roll over.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_ok   = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read responder backed by an internal word memory with a backdoor write port.
// Build macro AXI_RD_RESPONDER_SLVERR_EN enables SLVERR on out-of-range beats.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arready high, waiting for an AR handshake
// LOAD  | fetch first beat into the R output registers
// BURST | rvalid high; advance per accepted beat, back to IDLE after rlast
module axi_rd_responder
  import params_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = AXI_ID_WIDTH,
  parameter int C_AXI_ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int C_AXI_DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int C_AXI_LEN_WIDTH  = AXI_LEN_WIDTH,
  parameter int MEM_WORDS        = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [C_AXI_ID_WIDTH-1:0]     arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   araddr,
  input  logic [C_AXI_LEN_WIDTH-1:0]    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [C_AXI_ID_WIDTH-1:0]     rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  input  logic                          bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  bd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   bd_wdata
);

  localparam int WORD_AW  = $clog2(MEM_WORDS);
  localparam int MAX_SIZE = $clog2(C_AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BURST} state_e;

  state_e                        state;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]                    size_q;
  logic [C_AXI_LEN_WIDTH-1:0]    len_q;
  logic [C_AXI_LEN_WIDTH-1:0]    len_cnt;
  logic [1:0]                    burst_q;
  logic [C_AXI_ADDR_WIDTH-1:0]   next_addr;
  logic [2:0]                    size_clamped;

  logic [C_AXI_DATA_WIDTH-1:0]   mem [MEM_WORDS];
  logic [WORD_AW-1:0]            beat_idx;
  logic [C_AXI_DATA_WIDTH-1:0]   beat_data;
  logic [1:0]                    beat_resp;

  assign size_clamped = (arsize > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : arsize;

  axi_burst_addr #(
    .ADDR_WIDTH (C_AXI_ADDR_WIDTH),
    .LEN_WIDTH  (C_AXI_LEN_WIDTH)
  ) u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // LOAD fetches the captured address; an accepted beat in BURST fetches the next one.
  assign beat_idx = (state == S_LOAD) ? addr_q[MAX_SIZE +: WORD_AW]
                                      : next_addr[MAX_SIZE +: WORD_AW];

`ifdef AXI_RD_RESPONDER_SLVERR_EN
  logic beat_oor;

  assign beat_oor  = (state == S_LOAD) ? |addr_q[C_AXI_ADDR_WIDTH-1:MAX_SIZE+WORD_AW]
                                       : |next_addr[C_AXI_ADDR_WIDTH-1:MAX_SIZE+WORD_AW];
  assign beat_data = beat_oor ? '0 : mem[beat_idx];
  assign beat_resp = beat_oor ? RESP_SLVERR : RESP_OKAY;
`else
  assign beat_data = mem[beat_idx];
  assign beat_resp = RESP_OKAY;
`endif

  // Backdoor port; a same-edge read of this word still sees the old contents.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      len_cnt <= '0;
      burst_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            addr_q  <= araddr;
            size_q  <= size_clamped;
            len_q   <= arlen;
            len_cnt <= arlen;
            burst_q <= arburst;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          rvalid <= 1'b1;
          rdata  <= beat_data;
          rresp  <= beat_resp;
          rlast  <= (len_cnt == '0);
          state  <= S_BURST;
        end
        S_BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              state   <= S_IDLE;
            end else begin
              addr_q  <= next_addr;
              len_cnt <= len_cnt - 1'b1;
              rdata   <= beat_data;
              rresp   <= beat_resp;
              rlast   <= (len_cnt == C_AXI_LEN_WIDTH'(1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: table of bursts plus hand-written
// sequences for backdoor collision and mid-burst reset.
module tb_axi_rd_responder;
  import params_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid;
  logic        arready;
  logic [5:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [5:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_wdata;

  int checks = 0;
  int errors = 0;

  axi_rd_responder dut (
    .clk      (clk),
    .reset    (reset),
    .arvalid  (arvalid),
    .arready  (arready),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .rvalid   (rvalid),
    .rready   (rready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [5:0]        id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    bit                stall;
    logic [3:0][31:0]  exp_data;
    logic [3:0][1:0]   exp_resp;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  function automatic logic [31:0] aw(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [5:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input bit stall, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    vecs[i].id       = id;
    vecs[i].addr     = addr;
    vecs[i].len      = len;
    vecs[i].size     = size;
    vecs[i].burst    = burst;
    vecs[i].stall    = stall;
    vecs[i].exp_data = {d3, d2, d1, d0};
    vecs[i].exp_resp = '0;
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] data);
    bd_we    = 1'b1;
    bd_addr  = idx;
    bd_wdata = data;
    @(negedge clk);
    bd_we    = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    arvalid = 1'b1;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", {63'd0, arready}, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("load_rvalid_low", {63'd0, rvalid}, 64'd0);
  endtask

  task automatic collect(input string name, input logic [5:0] id, input logic [7:0] len,
                         input bit stall, input logic [3:0][31:0] ed, input logic [3:0][1:0] er);
    @(negedge clk);
    for (int b = 0; b <= int'(len); b++) begin
      chk({name, "_rvalid"}, {63'd0, rvalid}, 64'd1);
      chk({name, "_rdata"}, {32'd0, rdata}, {32'd0, ed[b]});
      chk({name, "_rresp"}, {62'd0, rresp}, {62'd0, er[b]});
      chk({name, "_rid"}, {58'd0, rid}, {58'd0, id});
      chk({name, "_rlast"}, {63'd0, rlast}, {63'd0, (b == int'(len))});
      if (stall) begin
        rready = 1'b0;
        @(negedge clk);
        chk({name, "_stall_rvalid"}, {63'd0, rvalid}, 64'd1);
        chk({name, "_stall_rdata"}, {32'd0, rdata}, {32'd0, ed[b]});
        chk({name, "_stall_rlast"}, {63'd0, rlast}, {63'd0, (b == int'(len))});
      end
      rready = 1'b1;
      @(negedge clk);
    end
    rready = 1'b0;
    chk({name, "_end_rvalid"}, {63'd0, rvalid}, 64'd0);
    chk({name, "_end_arready"}, {63'd0, arready}, 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    arvalid  = 1'b0;
    arid     = '0;
    araddr   = '0;
    arlen    = '0;
    arsize   = '0;
    arburst  = '0;
    rready   = 1'b0;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_wdata = '0;

    set_vec(0, 6'h01, 32'h0,   8'd3, 3'd2, BURST_INCR,  1'b0, aw(0), aw(1), aw(2), aw(3));
    set_vec(1, 6'h02, 32'h8,   8'd3, 3'd2, BURST_WRAP,  1'b0, aw(2), aw(3), aw(0), aw(1));
    set_vec(2, 6'h03, 32'h4,   8'd2, 3'd2, BURST_FIXED, 1'b1, aw(1), aw(1), aw(1), 32'h0);
`ifdef AXI_RD_RESPONDER_SLVERR_EN
    set_vec(3, 6'h04, 32'hFFC, 8'd1, 3'd2, BURST_INCR,  1'b1, 32'hDEAD_03FF, 32'h0, 32'h0, 32'h0);
    vecs[3].exp_resp[1] = RESP_SLVERR;
`else
    set_vec(3, 6'h04, 32'hFFC, 8'd1, 3'd2, BURST_INCR,  1'b1, 32'hDEAD_03FF, aw(0), 32'h0, 32'h0);
`endif
    set_vec(4, 6'h3F, 32'hC,   8'd0, 3'd2, BURST_INCR,  1'b0, aw(3), 32'h0, 32'h0, 32'h0);
    set_vec(5, 6'h0A, 32'h0,   8'd1, 3'd7, BURST_INCR,  1'b0, aw(0), aw(1), 32'h0, 32'h0);
    set_vec(6, 6'h0B, 32'h8,   8'd2, 3'd2, BURST_WRAP,  1'b0, aw(2), aw(3), aw(4), 32'h0);
    set_vec(7, 6'h0C, 32'h1,   8'd3, 3'd0, BURST_INCR,  1'b0, aw(0), aw(0), aw(0), aw(1));
    set_vec(8, 6'h0D, 32'h10,  8'd1, 3'd2, BURST_RSVD,  1'b0, aw(4), aw(5), 32'h0, 32'h0);
    set_vec(9, 6'h0E, 32'h1C,  8'd1, 3'd2, BURST_WRAP,  1'b1, aw(7), aw(6), 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
    chk("rst_rlast",   {63'd0, rlast},   64'd0);
    chk("rst_rid",     {58'd0, rid},     64'd0);
    chk("rst_rdata",   {32'd0, rdata},   64'd0);
    chk("rst_rresp",   {62'd0, rresp},   64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", {63'd0, arready}, 64'd1);

    for (int i = 0; i < 8; i++) bd_write(10'(i), aw(i));
    bd_write(10'd1023, 32'hDEAD_03FF);

    for (int i = 0; i < NVEC; i++) begin
      send_ar(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
      collect($sformatf("vec%0d", i), vecs[i].id, vecs[i].len, vecs[i].stall,
              vecs[i].exp_data, vecs[i].exp_resp);
    end

    // Backdoor write landing on the same edge as the LOAD read of that word.
    send_ar(6'h07, 32'h14, 8'd0, 3'd2, BURST_INCR);
    bd_we    = 1'b1;
    bd_addr  = 10'd5;
    bd_wdata = 32'h5555_0005;
    @(negedge clk);
    bd_we = 1'b0;
    chk("bd_old_rvalid", {63'd0, rvalid}, 64'd1);
    chk("bd_old_rdata", {32'd0, rdata}, {32'd0, aw(5)});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("bd_old_end_rvalid", {63'd0, rvalid}, 64'd0);
    send_ar(6'h08, 32'h14, 8'd0, 3'd2, BURST_INCR);
    collect("bd_new", 6'h08, 8'd0, 1'b0, {32'h0, 32'h0, 32'h0, 32'h5555_0005}, '0);

    // Reset in the middle of a long burst.
    send_ar(6'h11, 32'h0, 8'd7, 3'd2, BURST_INCR);
    rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_beat2_rdata", {32'd0, rdata}, {32'd0, aw(2)});
    chk("mid_beat2_rvalid", {63'd0, rvalid}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("mid_rst_arready", {63'd0, arready}, 64'd0);
    rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_arready", {63'd0, arready}, 64'd1);
    chk("mid_post_rvalid", {63'd0, rvalid}, 64'd0);
    send_ar(6'h05, 32'h0, 8'd0, 3'd2, BURST_INCR);
    collect("after_rst", 6'h05, 8'd0, 1'b0, {32'h0, 32'h0, 32'h0, aw(0)}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_responder.md
AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 SHALL have parameter C_AXI_ID_WIDTH, default params_pkg::AXI_ID_WIDTH (6), AR/R ID width.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default params_pkg::AXI_ADDR_WIDTH (32), byte address width.
REQ-003 SHALL have parameter C_AXI_DATA_WIDTH, default params_pkg::AXI_DATA_WIDTH (32), R data width.
REQ-004 SHALL have parameter C_AXI_LEN_WIDTH, default params_pkg::AXI_LEN_WIDTH (8), ARLEN width.
REQ-005 SHALL have parameter MEM_WORDS, default 1024, internal memory depth in data words (power of two).
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 async active-high reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have ports: arvalid in 1; arready out 1; arid in ID; araddr in ADDR; arlen in LEN; arsize in 3; arburst in 2.
REQ-008 SHALL have ports: rvalid out 1; rready in 1; rid out ID; rdata out DATA; rresp out 2; rlast out 1.
REQ-009 SHALL have ports: bd_we in 1 backdoor write enable; bd_addr in log2(MEM_WORDS) word index; bd_wdata in DATA.

Function
REQ-010 SHALL implement states IDLE, LOAD, BURST; one outstanding burst only.
REQ-011 IDLE: arready=1; arvalid&&arready captures arid/araddr/arlen/arsize/arburst, go to LOAD.
REQ-012 LOAD: arready=0; register rdata=mem[word(addr)], rresp, rlast=(arlen==0); go to BURST; first rvalid exactly 2 cycles after AR handshake.
REQ-013 BURST: rvalid=1, rid=captured arid; outputs SHALL hold stable while rvalid&&!rready.
REQ-014 On rvalid&&rready with !rlast: advance address, decrement beat count, load next beat into output registers same edge; no bubbles while rready=1.
REQ-015 On rvalid&&rready with rlast: go to IDLE, rvalid=0 next cycle; arready=1 that cycle (no back-to-back AR overlap).
REQ-016 Beat size SHALL be 2^arsize bytes; arsize > log2(DATA/8) SHALL be clamped to log2(DATA/8).
REQ-017 FIXED (0): address constant all beats; INCR (1) and reserved (3): address += 2^arsize; carry beyond ADDR width discarded.
REQ-018 WRAP (2): boundary = (arlen+1)*2^arsize aligned; address wraps to boundary low on reaching high end; arlen not in {1,3,7,15} treated as INCR.
REQ-019 Word index SHALL be address >> log2(DATA/8); rdata SHALL be the full word (no lane masking).
REQ-020 Backdoor write: bd_we writes mem[bd_addr] at clk edge; simultaneous read of same word SHALL return old data.
REQ-021 rresp=OKAY (0) unless REQ-025 applies.

Reset
REQ-022 Reset SHALL force state IDLE, arready=0 while asserted (1 first cycle after deassert), rvalid=0, rlast=0, rid=0, rdata=0, rresp=0; memory contents not reset.
REQ-023 Reset mid-burst SHALL abandon the burst immediately; no further R beats.

Configuration
REQ-024 Macro AXI_RD_RESPONDER_SLVERR_EN SHALL select range checking.
REQ-025 Defined: any beat whose word index >= MEM_WORDS (before truncation) returns rresp=SLVERR (2), rdata=0; burst still completes with full length.
REQ-026 Undefined: word index taken modulo MEM_WORDS; rresp always OKAY.

Structure
REQ-027 Burst type enum (FIXED/INCR/WRAP) and RRESP constants SHALL live in params_pkg alongside existing width parameters.
REQ-028 Next-address logic SHALL be sub-module axi_burst_addr (addr, size, len, burst -> next addr), reusable by a future write responder.

Verification
REQ-029 Preload mem[0..3]=A0..A3; AR INCR addr 0x0 len 3 size 2, rready=1 -> 4 beats A0..A3, rlast on 4th, first rvalid 2 cycles after AR.
REQ-030 AR WRAP addr 0x8 len 3 size 2 -> beats from words 2,3,0,1.
REQ-031 AR FIXED addr 0x4 len 2 -> three beats all mem[1]; rready toggled 1/0 -> data/rlast stable during stalls.
REQ-032 With macro, MEM_WORDS=1024, AR INCR addr 0xFFC len 1 -> beat0 OKAY, beat1 SLVERR rdata=0; without macro beat1 = mem[0] OKAY.
REQ-033 Assert reset during beat 2 of len-7 burst -> rvalid=0 within same cycle; after release, new AR arid=5 accepted and served with rid=5.
REQ-034 arlen=0, arid=0x3F -> single beat with rlast=1, rid=0x3F; arready returns high the cycle after it.
